// File: rtl/mem_responder.sv
// Data-memory responder: 8 KiB little-endian RAM serving load/store requests over
// valid/ready with error reporting. Optional saturating error counter: MEMRESP_ERRCNT_EN.
module mem_responder #(
  parameter int DEPTH_WORDS = 2048,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [12:0]         req_addr,
  input  logic                req_inv,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          req_ready_r, req_ready_s;
  logic          rsp_valid_r, rsp_valid_s;
  logic [1:0]    rsp_err_r, rsp_err_s;
  logic [31:0]   rsp_rdata_r, rsp_rdata_s;

  logic          cap_we_r;
  logic [1:0]    cap_size_r;
  logic          cap_signed_r;
  logic [12:0]   cap_addr_r;
  logic [31:0]   cap_wdata_r;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_word_r;

  logic          accept_s;
  logic          rsp_hs_s;
  logic          range_err_s;
  logic          misalign_s;
  logic [1:0]    req_err_s;
  logic [AW-1:0] req_idx_s;
  logic [AW-1:0] cap_idx_s;
  logic          wr_en_s;
  logic [3:0]    wr_be_s;
  logic [31:0]   wr_lane_s;

  // Shift the addressed lanes down to bit 0, then zero- or sign-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  assign accept_s    = (state_r == IDLE) & req_valid & req_ready_r;
  assign rsp_hs_s    = rsp_valid_r & rsp_ready;
  assign req_idx_s   = req_addr[AW+1:2];
  assign cap_idx_s   = cap_addr_r[AW+1:2];
  assign range_err_s = ({21'd0, req_addr[12:2]} >= 32'(DEPTH_WORDS));

  // Request classification: invalid/out-of-range wins over misalignment.
  always_comb begin
    misalign_s = 1'b0;
    case (req_size)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = req_addr[0];
      2'd2:    misalign_s = |req_addr[1:0];
      default: misalign_s = 1'b1;
    endcase
    if (req_inv || range_err_s) begin
      req_err_s = 2'd1;
    end else if (misalign_s) begin
      req_err_s = 2'd2;
    end else begin
      req_err_s = 2'd0;
    end
  end

  // Store byte enables and lane-replicated write data from the captured request.
  always_comb begin
    wr_be_s   = 4'b1111;
    wr_lane_s = cap_wdata_r;
    case (cap_size_r)
      2'd0: begin
        wr_be_s   = 4'b0001 << cap_addr_r[1:0];
        wr_lane_s = {4{cap_wdata_r[7:0]}};
      end
      2'd1: begin
        wr_be_s   = cap_addr_r[1] ? 4'b1100 : 4'b0011;
        wr_lane_s = {2{cap_wdata_r[15:0]}};
      end
      default: begin
        wr_be_s   = 4'b1111;
        wr_lane_s = cap_wdata_r;
      end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    rsp_valid_s = rsp_valid_r;
    rsp_err_s   = rsp_err_r;
    rsp_rdata_s = rsp_rdata_r;
    wr_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_err_s != 2'd0) begin
            state_s     = RESP;
            rsp_valid_s = 1'b1;
            rsp_err_s   = req_err_s;
            rsp_rdata_s = 32'd0;
          end else begin
            state_s = ACCESS;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        state_s     = RESP;
        wr_en_s     = cap_we_r;
        rsp_valid_s = 1'b1;
        rsp_err_s   = 2'd0;
        if (cap_we_r) begin
          rsp_rdata_s = 32'd0;
        end else begin
          rsp_rdata_s = load_extend(rd_word_r, cap_size_r, cap_addr_r[1:0], cap_signed_r);
        end
      end
      RESP: begin
        if (rsp_hs_s) begin
          state_s     = IDLE;
          rsp_valid_s = 1'b0;
          rsp_err_s   = 2'd0;
          rsp_rdata_s = 32'd0;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s     = IDLE;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 2'd0;
        rsp_rdata_s = 32'd0;
      end
    endcase
    req_ready_s = (state_s == IDLE);
  end

  // FSM state and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 2'd0;
      rsp_rdata_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_rdata_r <= rsp_rdata_s;
    end
  end

  // Capture of the accepted request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_we_r     <= 1'b0;
      cap_size_r   <= 2'd0;
      cap_signed_r <= 1'b0;
      cap_addr_r   <= 13'd0;
      cap_wdata_r  <= 32'd0;
    end else if (accept_s) begin
      cap_we_r     <= req_we;
      cap_size_r   <= req_size;
      cap_signed_r <= req_signed;
      cap_addr_r   <= req_addr;
      cap_wdata_r  <= req_wdata;
    end
  end

  // RAM: lane-masked write in ACCESS; the word is read at acceptance so the
  // extended result can be registered on the ACCESS edge. A reset low at that
  // edge forces IDLE asynchronously and so suppresses the write.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_s[i]) begin
          mem[cap_idx_s][8*i +: 8] <= wr_lane_s[8*i +: 8];
        end
      end
    end
    if (accept_s) begin
      rd_word_r <= mem[req_idx_s];
    end
  end

`ifdef MEMRESP_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_r;

  // Saturating count of error responses, advanced on their handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_r <= {ERRCNT_W{1'b0}};
    end else if (rsp_hs_s && (rsp_err_r != 2'd0) && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err_count = err_cnt_r;
`else
  assign err_count = {ERRCNT_W{1'b0}};
`endif

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule
